// File: rtl/amstrad_mem_arbiter.sv
// ---------------------------------------------------------------------------
// amstrad_mem_arbiter
//
// Shares the single external RAM port between three requesters:
//   - video fetch from the gate array (16-bit words, bank 0)
//   - CPU byte accesses (already translated by the MMU)
//   - bulk loader byte writes (tape/disk/ROM injection)
// A three-state FSM (IDLE -> ISSUE -> DONE) owns one RAM transaction at a
// time. The RAM-side outputs are latched when a request is granted, so
// requester inputs may change freely once the grant has been made.
//
// Priority: video > loader-if-starved > CPU > loader.
// A 3-bit starvation counter lets the loader in after seven consecutive CPU
// grants made while the loader was waiting.
//
// Build option:
//   MEMARB_LOADER_EN  defined   -> loader port, starvation counter and loader
//                                  arbitration are present.
//                     undefined -> ld_req is ignored, ld_ack is tied low and
//                                  priority is video > CPU. The ld_* inputs
//                                  stay in the port list for pin compatibility.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   vid_req/vid_addr             video request and word address
//   vid_data/vid_ack             fetched word and completion pulse
//   cpu_req/cpu_we/cpu_addr/cpu_wdata   CPU request
//   cpu_rdata/cpu_ack/cpu_wait   CPU read byte, completion pulse, Z80 wait
//   ld_req/ld_addr/ld_wdata      loader write request
//   ld_ack                       loader completion pulse
//   ram_req/ram_we/ram_addr/ram_wdata   RAM request side
//   ram_rdata/ram_ack            RAM read word and completion pulse
// ---------------------------------------------------------------------------
module amstrad_mem_arbiter (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        vid_req,
    input  logic [14:0] vid_addr,
    output logic [15:0] vid_data,
    output logic        vid_ack,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [22:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_wait,

    input  logic        ld_req,
    input  logic [22:0] ld_addr,
    input  logic [7:0]  ld_wdata,
    output logic        ld_ack,

    output logic        ram_req,
    output logic        ram_we,
    output logic [22:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [15:0] ram_rdata,
    input  logic        ram_ack
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_VID = 2'd0,
        OWN_CPU = 2'd1,
        OWN_LD  = 2'd2
    } owner_t;

    state_t      r_state;
    state_t      w_state_nxt;
    owner_t      r_owner;
    owner_t      w_grant;
    logic        w_any_req;
    logic        w_grant_en;
    logic        w_complete;

    logic        r_ram_req;
    logic        r_ram_we;
    logic [22:0] r_ram_addr;
    logic [7:0]  r_ram_wdata;
    logic [15:0] r_vid_data;
    logic [7:0]  r_cpu_rdata;
    logic        r_vid_ack;
    logic        r_cpu_ack;

`ifdef MEMARB_LOADER_EN
    logic [2:0]  r_starve;
    logic        r_ld_ack;
`else
    // Loader inputs are kept only for pin compatibility.
    logic        w_unused_ld;
    assign w_unused_ld = ^{ld_req, ld_addr, ld_wdata};
`endif

    // -----------------------------------------------------------------------
    // Arbitration: pick the winner among the requests pending right now.
    // Only consulted in IDLE.
    // -----------------------------------------------------------------------
    always_comb begin
        w_grant   = OWN_CPU;
        w_any_req = 1'b0;
        if (vid_req) begin
            w_grant   = OWN_VID;
            w_any_req = 1'b1;
        end
`ifdef MEMARB_LOADER_EN
        // A loader that has watched seven CPU grants go by jumps the CPU.
        else if (ld_req && (r_starve == 3'd7)) begin
            w_grant   = OWN_LD;
            w_any_req = 1'b1;
        end else if (cpu_req) begin
            w_grant   = OWN_CPU;
            w_any_req = 1'b1;
        end else if (ld_req) begin
            w_grant   = OWN_LD;
            w_any_req = 1'b1;
        end
`else
        else if (cpu_req) begin
            w_grant   = OWN_CPU;
            w_any_req = 1'b1;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and per-cycle strobes
    // ram_ack is only honoured in ISSUE, so a stray or late ack (e.g. from a
    // transaction abandoned by reset) is ignored.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant_en  = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_ISSUE;
                    w_grant_en  = 1'b1;
                end
            end
            S_ISSUE: begin
                if (ram_ack) begin
                    w_state_nxt = S_DONE;
                    w_complete  = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: latch the RAM request at grant, capture read data and raise
    // the owner's ack at completion. Acks are single-cycle (cleared every
    // cycle unless set), which places them in the DONE cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_owner     <= OWN_VID;
            r_ram_req   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_vid_data  <= '0;
            r_cpu_rdata <= '0;
            r_vid_ack   <= 1'b0;
            r_cpu_ack   <= 1'b0;
        end else begin
            r_vid_ack <= 1'b0;
            r_cpu_ack <= 1'b0;

            if (w_grant_en) begin
                r_owner   <= w_grant;
                r_ram_req <= 1'b1;
                case (w_grant)
                    OWN_VID: begin
                        r_ram_addr  <= {7'b0, vid_addr, 1'b0};
                        r_ram_we    <= 1'b0;
                        r_ram_wdata <= 8'h00;
                    end
                    OWN_CPU: begin
                        r_ram_addr  <= cpu_addr;
                        r_ram_we    <= cpu_we;
                        r_ram_wdata <= cpu_wdata;
                    end
                    default: begin
                        r_ram_addr  <= ld_addr;
                        r_ram_we    <= 1'b1;
                        r_ram_wdata <= ld_wdata;
                    end
                endcase
            end

            if (w_complete) begin
                r_ram_req <= 1'b0;
                case (r_owner)
                    OWN_VID: begin
                        r_vid_data <= ram_rdata;
                        r_vid_ack  <= 1'b1;
                    end
                    OWN_CPU: begin
                        // RAM returns the even-aligned word; the latched byte
                        // address picks the lane. Writes leave rdata alone.
                        if (!r_ram_we) begin
                            r_cpu_rdata <= r_ram_addr[0] ? ram_rdata[15:8]
                                                         : ram_rdata[7:0];
                        end
                        r_cpu_ack <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef MEMARB_LOADER_EN
    // -----------------------------------------------------------------------
    // Loader ack and starvation counter. The counter only moves in IDLE:
    // it clears whenever the loader is not waiting or has just won, and
    // counts CPU grants that overtook a waiting loader. A waiting loader
    // wins at 7, so the count never needs to wrap.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ld_ack <= 1'b0;
            r_starve <= 3'd0;
        end else begin
            r_ld_ack <= w_complete && (r_owner == OWN_LD);
            if (r_state == S_IDLE) begin
                if (!ld_req) begin
                    r_starve <= 3'd0;
                end else if (w_grant_en && (w_grant == OWN_LD)) begin
                    r_starve <= 3'd0;
                end else if (w_grant_en && (w_grant == OWN_CPU) && (r_starve != 3'd7)) begin
                    r_starve <= r_starve + 3'd1;
                end
            end
        end
    end

    assign ld_ack = r_ld_ack;
`else
    assign ld_ack = 1'b0;
`endif

    assign ram_req   = r_ram_req;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign vid_data  = r_vid_data;
    assign vid_ack   = r_vid_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign cpu_ack   = r_cpu_ack;

    // Z80 wait follows the request combinationally and drops with the ack.
    assign cpu_wait  = cpu_req & ~r_cpu_ack;

endmodule

// File: tb/tb_amstrad_mem_arbiter.sv
// Testbench for amstrad_mem_arbiter: directed scenarios followed by
// randomized traffic checked against a priority/starvation reference model.
module tb_amstrad_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vid_req;
    logic [14:0] vid_addr;
    logic [15:0] vid_data;
    logic        vid_ack;
    logic        cpu_req;
    logic        cpu_we;
    logic [22:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        cpu_wait;
    logic        ld_req;
    logic [22:0] ld_addr;
    logic [7:0]  ld_wdata;
    logic        ld_ack;
    logic        ram_req;
    logic        ram_we;
    logic [22:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [15:0] ram_rdata;
    logic        ram_ack;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    amstrad_mem_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .vid_ack   (vid_ack),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .cpu_wait  (cpu_wait),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_ack    (ld_ack),
        .ram_req   (ram_req),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ack   (ram_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for ram_req, captures the request, holds it for dly
    // extra cycles checking stability, then acks with rd. Returns in the
    // cycle where the owner's ack should be visible.
    task automatic serve(input int dly, input logic [15:0] rd,
                         output logic [22:0] a, output logic we,
                         output logic [7:0] wd, output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (!ram_req && n < 20) begin
            tick();
            n++;
        end
        chk("serve_ram_req", 32'(ram_req), 1);
        a  = ram_addr;
        we = ram_we;
        wd = ram_wdata;
        if (!ram_req) begin
            ok = 1'b0;
            return;
        end
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("serve_hold_req", 32'(ram_req), 1);
            chk("serve_hold_addr", 32'(ram_addr), 32'(a));
            chk("serve_hold_wdata", 32'(ram_wdata), 32'(wd));
        end
        ram_ack   = 1'b1;
        ram_rdata = rd;
        tick();
        ram_ack   = 1'b0;
        ram_rdata = 16'($urandom);
    endtask

    logic [22:0] a;
    logic        we;
    logic [7:0]  wd;
    bit          ok;
    logic [15:0] rd;
    bit          vp, cp, lp;
    int          w;
    int          starve;
    logic [7:0]  exp_crd;
    logic [15:0] exp_vd;

    initial begin
        reset_n   = 1'b0;
        vid_req   = 1'b0; vid_addr = '0;
        cpu_req   = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ld_req    = 1'b0; ld_addr = '0; ld_wdata = '0;
        ram_rdata = '0;   ram_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // ---- reset state
        chk("rst_ram_req",   32'(ram_req), 0);
        chk("rst_ram_we",    32'(ram_we), 0);
        chk("rst_ram_addr",  32'(ram_addr), 0);
        chk("rst_ram_wdata", 32'(ram_wdata), 0);
        chk("rst_vid_data",  32'(vid_data), 0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
        chk("rst_acks",      32'({vid_ack, cpu_ack, ld_ack}), 0);
        reset_n = 1'b1;
        tick();

        // ---- CPU read, ram_ack in first ISSUE cycle
        cpu_addr = 23'h004001; cpu_we = 1'b0; cpu_req = 1'b1;
        #1;
        chk("t1_wait_c0", 32'(cpu_wait), 1);
        chk("t1_req_c0", 32'(ram_req), 0);
        tick();
        chk("t1_req_c1", 32'(ram_req), 1);
        chk("t1_addr", 32'(ram_addr), 'h004001);
        chk("t1_we", 32'(ram_we), 0);
        chk("t1_wait_c1", 32'(cpu_wait), 1);
        chk("t1_ack_c1", 32'(cpu_ack), 0);
        ram_ack = 1'b1; ram_rdata = 16'hA55A;
        tick();
        ram_ack = 1'b0; ram_rdata = 16'h0000;
        chk("t1_ack_c2", 32'(cpu_ack), 1);
        chk("t1_rdata", 32'(cpu_rdata), 'hA5);
        chk("t1_wait_c2", 32'(cpu_wait), 0);
        chk("t1_req_c2", 32'(ram_req), 0);
        cpu_req = 1'b0;
        tick();
        chk("t1_ack_c3", 32'(cpu_ack), 0);

        // ---- simultaneous video + CPU
        vid_addr = 15'h1234; vid_req = 1'b1;
        cpu_addr = 23'h000123; cpu_we = 1'b0; cpu_req = 1'b1;
        tick();
        chk("t2_vaddr", 32'(ram_addr), 'h002468);
        chk("t2_vwe", 32'(ram_we), 0);
        ram_ack = 1'b1; ram_rdata = 16'hBEEF;
        tick();
        ram_ack = 1'b0;
        chk("t2_vack", 32'(vid_ack), 1);
        chk("t2_cack_early", 32'(cpu_ack), 0);
        chk("t2_vdata", 32'(vid_data), 'hBEEF);
        chk("t2_cwait", 32'(cpu_wait), 1);
        vid_req = 1'b0;
        tick();
        chk("t2_idle_req", 32'(ram_req), 0);
        tick();
        chk("t2_creq", 32'(ram_req), 1);
        chk("t2_caddr", 32'(ram_addr), 'h000123);
        ram_ack = 1'b1; ram_rdata = 16'h1357;
        tick();
        ram_ack = 1'b0;
        chk("t2_cack", 32'(cpu_ack), 1);
        chk("t2_crdata_hi", 32'(cpu_rdata), 'h13);
        cpu_req = 1'b0;
        tick();

        // ---- CPU write with ram_ack 5 cycles after ram_req
        cpu_addr = 23'h010000; cpu_we = 1'b1; cpu_wdata = 8'h3C; cpu_req = 1'b1;
        tick();
        for (int i = 1; i <= 5; i++) begin
            chk("t5_req", 32'(ram_req), 1);
            chk("t5_addr", 32'(ram_addr), 'h010000);
            chk("t5_wdata", 32'(ram_wdata), 'h3C);
            chk("t5_we", 32'(ram_we), 1);
            chk("t5_noack", 32'(cpu_ack), 0);
            tick();
        end
        ram_ack = 1'b1; ram_rdata = 16'hFFFF;
        tick();
        ram_ack = 1'b0;
        chk("t5_ack", 32'(cpu_ack), 1);
        chk("t5_rdata_kept", 32'(cpu_rdata), 'h13);
        cpu_req = 1'b0; cpu_we = 1'b0;
        tick();

        // ---- reset while in ISSUE, late ram_ack afterwards
        cpu_addr = 23'h000042; cpu_req = 1'b1;
        tick();
        chk("t4_issue", 32'(ram_req), 1);
        reset_n = 1'b0; cpu_req = 1'b0;
        #1;
        chk("t4_rst_req", 32'(ram_req), 0);
        chk("t4_rst_addr", 32'(ram_addr), 0);
        chk("t4_rst_we", 32'(ram_we), 0);
        chk("t4_rst_vdata", 32'(vid_data), 0);
        chk("t4_rst_crdata", 32'(cpu_rdata), 0);
        chk("t4_rst_acks", 32'({vid_ack, cpu_ack, ld_ack, cpu_wait}), 0);
        tick();
        chk("t4_rst_req2", 32'(ram_req), 0);
        reset_n = 1'b1;
        tick();
        ram_ack = 1'b1; ram_rdata = 16'hAAAA;
        tick();
        ram_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_no_ack", 32'({vid_ack, cpu_ack, ld_ack}), 0);
            chk("t4_idle", 32'(ram_req), 0);
            chk("t4_crdata", 32'(cpu_rdata), 0);
            tick();
        end

        // ---- loader and CPU both held
        cpu_addr = 23'h0000F0; cpu_we = 1'b0; cpu_req = 1'b1;
        ld_addr  = 23'h7ABCDE; ld_wdata = 8'h5D; ld_req = 1'b1;
        for (int g = 0; g < 16; g++) begin
            serve(g % 3, 16'h0000, a, we, wd, ok);
            if (!ok) break;
`ifdef MEMARB_LOADER_EN
            if (g % 8 == 7) begin
                chk("t3_ld_addr", 32'(a), 'h7ABCDE);
                chk("t3_ld_we", 32'(we), 1);
                chk("t3_ld_wdata", 32'(wd), 'h5D);
                chk("t3_ld_acks", 32'({ld_ack, cpu_ack}), 'b10);
            end else begin
                chk("t3_cpu_addr", 32'(a), 'h0000F0);
                chk("t3_cpu_we", 32'(we), 0);
                chk("t3_cpu_acks", 32'({ld_ack, cpu_ack}), 'b01);
            end
`else
            chk("t6_cpu_addr", 32'(a), 'h0000F0);
            chk("t6_cpu_acks", 32'({ld_ack, cpu_ack}), 'b01);
`endif
        end
        cpu_req = 1'b0; ld_req = 1'b0;
        tick();
        tick();

        // ---- randomized traffic against the reference model
        vp = 1'b0; cp = 1'b0; lp = 1'b0;
        starve  = 0;
        exp_crd = 8'h00;
        exp_vd  = 16'h0000;
        for (int it = 0; it < 80; it++) begin
            if (!vp && $urandom_range(0, 2) == 0) begin
                vp = 1'b1; vid_addr = 15'($urandom); vid_req = 1'b1;
            end
            if (!cp && $urandom_range(0, 1) == 1) begin
                cp = 1'b1; cpu_addr = 23'($urandom); cpu_we = 1'($urandom);
                cpu_wdata = 8'($urandom); cpu_req = 1'b1;
            end
            if (!lp && $urandom_range(0, 1) == 1) begin
                lp = 1'b1; ld_addr = 23'($urandom); ld_wdata = 8'($urandom); ld_req = 1'b1;
            end
`ifdef MEMARB_LOADER_EN
            if (!vp && !cp && !lp) begin
                lp = 1'b1; ld_addr = 23'($urandom); ld_wdata = 8'($urandom); ld_req = 1'b1;
            end
`else
            if (!vp && !cp) begin
                cp = 1'b1; cpu_addr = 23'($urandom); cpu_we = 1'($urandom);
                cpu_wdata = 8'($urandom); cpu_req = 1'b1;
            end
`endif
            // Expected winner: 0 video, 1 CPU, 2 loader.
            if (vp) w = 0;
`ifdef MEMARB_LOADER_EN
            else if (lp && starve == 7) w = 2;
            else if (cp) w = 1;
            else w = 2;
            if (!lp || w == 2) starve = 0;
            else if (w == 1) starve = starve + 1;
`else
            else w = 1;
`endif
            rd = 16'($urandom);
            serve($urandom_range(0, 3), rd, a, we, wd, ok);
            if (!ok) break;
            case (w)
                0: begin
                    chk("r_vid_addr", 32'(a), 32'({7'b0, vid_addr, 1'b0}));
                    chk("r_vid_we", 32'(we), 0);
                    exp_vd = rd;
                end
                1: begin
                    chk("r_cpu_addr", 32'(a), 32'(cpu_addr));
                    chk("r_cpu_we", 32'(we), 32'(cpu_we));
                    if (cpu_we) chk("r_cpu_wdata", 32'(wd), 32'(cpu_wdata));
                    else exp_crd = cpu_addr[0] ? rd[15:8] : rd[7:0];
                end
                default: begin
                    chk("r_ld_addr", 32'(a), 32'(ld_addr));
                    chk("r_ld_we", 32'(we), 1);
                    chk("r_ld_wdata", 32'(wd), 32'(ld_wdata));
                end
            endcase
            chk("r_vid_ack", 32'(vid_ack), 32'(w == 0));
            chk("r_cpu_ack", 32'(cpu_ack), 32'(w == 1));
            chk("r_ld_ack", 32'(ld_ack), 32'(w == 2));
            chk("r_vid_data", 32'(vid_data), 32'(exp_vd));
            chk("r_cpu_rdata", 32'(cpu_rdata), 32'(exp_crd));
            chk("r_cpu_wait", 32'(cpu_wait), 32'(cp && w != 1));
            case (w)
                0:       begin vid_req = 1'b0; vp = 1'b0; end
                1:       begin cpu_req = 1'b0; cp = 1'b0; end
                default: begin ld_req  = 1'b0; lp = 1'b0; end
            endcase
        end
        vid_req = 1'b0; cpu_req = 1'b0; ld_req = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/amstrad_mem_arbiter.md
# amstrad_mem_arbiter

Arbitrates the single external RAM port between three requesters: video fetch from the gate array (16-bit words), CPU memory accesses (bytes, after MMU translation) and an optional bulk loader (byte writes from tape/disk/ROM injection). It sits between the motherboard datapath and the SDRAM controller. It drives the CPU wait request, so the Z80 stalls while its access is pending.

## Interface
No parameters.
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- vid_req  in  1  video fetch request, level, held until vid_ack
- vid_addr  in  15  video word address (bank 0)
- vid_data  out  16  fetched word, valid from vid_ack onward
- vid_ack  out  1  one-cycle completion pulse
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  23  byte address (MMU output)
- cpu_wdata  in  8  write data
- cpu_rdata  out  8  read byte, valid from cpu_ack onward
- cpu_ack  out  1  one-cycle completion pulse
- cpu_wait  out  1  combinational cpu_req & ~cpu_ack; to Z80 wait logic
- ld_req  in  1  loader write request, level
- ld_addr  in  23  loader byte address
- ld_wdata  in  8  loader data
- ld_ack  out  1  one-cycle completion pulse
- ram_req  out  1  RAM request, held until ram_ack
- ram_we  out  1  RAM write strobe
- ram_addr  out  23  RAM byte address
- ram_wdata  out  8  RAM write byte
- ram_rdata  in  16  RAM read word (even-aligned)
- ram_ack  in  1  one-cycle completion pulse from RAM controller

## Operation
- FSM states:
  - IDLE: arbitrate among pending requests.
  - ISSUE: ram_req high; address, we and data stable.
  - DONE: pulse the owner's ack; ram_req low.
- IDLE with any request pending: latch the owner, load the RAM outputs and go to ISSUE. With no request pending, stay in IDLE.
- ISSUE: on ram_ack, latch read data and go to DONE.
- DONE: always returns to IDLE on the next cycle.
- Priority: video > loader-if-starved > CPU > loader.
- Starvation counter (3 bits):
  - Increments on each CPU grant made while ld_req is high.
  - At value 7, the next arbitration with ld_req high grants the loader over the CPU. The loader never wins over video.
  - Clears on a loader grant, or in any IDLE cycle with ld_req low.
- Video grant: ram_addr = {7'b0, vid_addr, 1'b0}, ram_we = 0. vid_data is latched from ram_rdata.
- CPU grant: ram_addr = cpu_addr, ram_we = cpu_we, ram_wdata = cpu_wdata.
  - On a read, cpu_rdata = cpu_addr[0] ? ram_rdata[15:8] : ram_rdata[7:0].
  - On a write, cpu_rdata keeps its previous value.
- Loader grant: ram_addr = ld_addr, ram_we = 1, ram_wdata = ld_wdata.
- Requesters drop req in the cycle after ack. A req still high in IDLE is treated as a new request.
- ram_ack outside ISSUE is ignored.
- Request inputs change only while IDLE or after ack. Changes during ISSUE are ignored, because the outputs are latched at grant.

## Timing
- Reset values: state IDLE, all acks 0, ram_req 0, ram_we 0, ram_addr 0, ram_wdata 0, vid_data 0, cpu_rdata 0, starvation counter 0.
- Latency:
  - Request sampled in IDLE at cycle 0.
  - ram_req high from cycle 1.
  - ram_ack in cycle n ≥ 1.
  - Owner ack in cycle n+1.
  - Minimum request-to-ack is 2 cycles.
- Back-to-back: a new grant is possible in the cycle after DONE, which gives a 3-cycle minimum per transaction.
- Simultaneous requests in IDLE are resolved by priority only. No request is lost: losers stay pending with req held.
- Async reset mid-transaction:
  - Immediately forces IDLE and clears all outputs.
  - The outstanding RAM transaction is abandoned, and its late ram_ack is ignored.
  - No ack is issued for it.
- cpu_wait is combinational, with no register delay. It is high from the cpu_req rising edge through the cycle before cpu_ack.

## Configuration
- MEMARB_LOADER_EN defined: the loader port, the starvation counter and loader arbitration are present as described.
- MEMARB_LOADER_EN undefined:
  - ld_req is ignored and ld_ack is tied to 0.
  - The starvation counter is removed.
  - Priority becomes video > CPU.
  - The ld_* input ports remain in the port list for pin compatibility.

## Test plan
- CPU read, ram_ack returned 1 cycle after ram_req, with cpu_addr=23'h004001 and ram_rdata=16'hA55A:
  - ram_addr=23'h004001 and ram_we=0.
  - cpu_ack at cycle 2 with cpu_rdata=8'hA5.
  - cpu_wait high during cycles 0–1.
- vid_req and cpu_req raised in the same cycle, with vid_addr=15'h1234:
  - First grant is video: ram_addr=23'h002468, and vid_ack comes before the CPU is granted.
  - CPU is granted in the cycle after DONE.
- ld_req and cpu_req held continuously, with the CPU re-requesting after each ack (MEMARB_LOADER_EN defined):
  - 7 CPU grants, then 1 loader grant with ram_we=1 and ram_wdata=ld_wdata.
  - The pattern repeats.
- Assert reset_n=0 while in ISSUE, then assert ram_ack 1 cycle after release:
  - All outputs are 0 during reset.
  - No ack is pulsed.
  - The FSM stays in IDLE.
- CPU write of 8'h3C to 23'h010000 with ram_ack delayed 5 cycles:
  - ram_req, ram_addr and ram_wdata stay stable for 5 cycles.
  - cpu_ack arrives 1 cycle after ram_ack.
  - cpu_rdata is unchanged.
- MEMARB_LOADER_EN undefined, ld_req held high:
  - ld_ack is never asserted.
  - The CPU is granted on every arbitration.
